// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian 512x8 data memory with a byte-serial
// load/store controller and one-cycle MOC/ERR completion pulses.
//
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   start           : request strobe, sampled only when idle
//   mem_write       : 1 = store, 0 = load
//   size            : 00 byte, 01 halfword, 10 word, 11 reserved (err)
//   sign_ext        : loads only, 1 = sign-extend, 0 = zero-extend
//   addr [ADDR_W]   : byte address of the lowest (most significant) byte
//   wdata[32]       : store data, low-order bytes used for byte/half
//   rdata[32]       : last completed load result
//   moc, err        : one-cycle completion / error pulse
//   busy            : high from request acceptance until the pulse ends
//
// Build option: ALIGN_CHECK_EN rejects misaligned halfword/word accesses.

module mem_access_unit #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              moc,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0]        r_mem [DEPTH];
  logic              r_we;
  logic              r_sx;
  logic              r_err;
  logic [1:0]        r_size;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic [31:0]       r_asm;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_bad;
  logic              w_end;
  logic [1:0]        w_last_idx;
  logic [7:0]        w_rbyte;
  logic [31:0]       w_wd_al;
  logic [31:0]       w_asm_nx;
  logic [31:0]       w_ext;

`ifdef ALIGN_CHECK_EN
  assign w_bad = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign w_bad = (size == 2'b11);
`endif

  assign w_accept = (r_state == IDLE) & start;
  assign w_end    = (r_cnt == r_last);
  assign w_rbyte  = r_mem[r_addr];
  assign w_asm_nx = {r_asm[23:0], w_rbyte};

  // Store data is left-aligned so every transfer takes the top byte.
  always_comb begin
    w_wd_al    = wdata;
    w_last_idx = 2'd3;
    case (size)
      2'b00: begin
        w_wd_al    = {wdata[7:0], 24'h0};
        w_last_idx = 2'd0;
      end
      2'b01: begin
        w_wd_al    = {wdata[15:0], 16'h0};
        w_last_idx = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ext = w_asm_nx;
    case (r_size)
      2'b00:
        w_ext = {{24{r_sx & w_asm_nx[7]}}, w_asm_nx[7:0]};
      2'b01:
        w_ext = {{16{r_sx & w_asm_nx[15]}}, w_asm_nx[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = w_bad ? DONE : XFER;
        end
      end
      XFER: begin
        if (w_end) begin
          w_state_nx = DONE;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_sx    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_cnt   <= 2'd0;
      r_last  <= 2'd0;
      r_addr  <= '0;
      r_wd    <= 32'h0;
      r_asm   <= 32'h0;
      r_rdata <= 32'h0;
    end else if (w_accept) begin
      r_we    <= mem_write;
      r_sx    <= sign_ext;
      r_err   <= w_bad;
      r_size  <= size;
      r_cnt   <= 2'd0;
      r_last  <= w_last_idx;
      r_addr  <= addr;
      r_wd    <= w_wd_al;
      r_asm   <= 32'h0;
    end else if (r_state == XFER) begin
      r_cnt   <= r_cnt + 2'd1;
      r_addr  <= r_addr + ADDR_W'(1);
      r_wd    <= {r_wd[23:0], 8'h0};
      r_asm   <= w_asm_nx;
      if (w_end && !r_we) begin
        r_rdata <= w_ext;
      end
    end
  end

  // Not reset; a reset edge during a store must not write that byte.
  always_ff @(posedge clock) begin
    if (!reset && (r_state == XFER) && r_we) begin
      r_mem[r_addr] <= r_wd[31:24];
    end
  end

  assign rdata = r_rdata;
  assign busy  = (r_state != IDLE);
  assign moc   = (r_state == DONE) & ~r_err;
  assign err   = (r_state == DONE) & r_err;

endmodule
